// File: rtl/sr_cmd_sequencer.sv
// Debounces two raw request lines and issues mutually exclusive one-cycle S/R pulses
// with a hold-off window. Optional macro SR_CMD_REDUNDANT_FILTER_EN drops redundant requests.
module sr_cmd_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 2,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic s_raw,
  input  logic r_raw,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict,
  output logic q_shadow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

`ifdef SR_CMD_REDUNDANT_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // Bit 0 carries the set channel, bit 1 the clear channel.
  logic [1:0]       raw_sync_q, raw_sync_d;
  logic [1:0]       level_q, level_d;
  logic [1:0]       level_prev_q, level_prev_d;
  logic [CNT_W-1:0] deb_cnt_q [2];
  logic [CNT_W-1:0] deb_cnt_d [2];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_set_q, pend_set_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             conflict_q, conflict_d;
  logic             q_shadow_q, q_shadow_d;

  logic s_req, r_req, both_req, s_ok, r_ok;
  logic launch, launch_set;

  always_comb begin
    raw_sync_d   = {r_raw, s_raw};
    level_d      = level_q;
    level_prev_d = level_q;
    deb_cnt_d    = '{default: '0};
    for (int i = 0; i < 2; i++) begin
      if (raw_sync_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          level_d[i] = raw_sync_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign s_req    = level_q[0] & ~level_prev_q[0];
  assign r_req    = level_q[1] & ~level_prev_q[1];
  assign both_req = s_req & r_req;
  // A request is "ok" unless the filter is on and it would not move q_shadow.
  assign s_ok     = s_req & ~(FILTER_EN & q_shadow_q);
  assign r_ok     = r_req & ~(FILTER_EN & ~q_shadow_q);

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_set_d   = pend_set_q;
    s_d          = 1'b0;
    r_d          = 1'b0;
    conflict_d   = 1'b0;
    q_shadow_d   = q_shadow_q;
    launch       = 1'b0;
    launch_set   = 1'b0;

    case (state_q)
      IDLE: begin
        if (both_req) begin
          conflict_d = 1'b1;
        end else if (s_ok) begin
          launch     = 1'b1;
          launch_set = 1'b1;
        end else if (r_ok) begin
          launch     = 1'b1;
          launch_set = 1'b0;
        end
      end
      FIRE, HOLDOFF: begin
        if (both_req) begin
          conflict_d   = 1'b1;
          pend_valid_d = 1'b0;
        end else if (s_ok) begin
          pend_valid_d = 1'b1;
          pend_set_d   = 1'b1;
        end else if (r_ok) begin
          pend_valid_d = 1'b1;
          pend_set_d   = 1'b0;
        end

        if (state_q == FIRE && HOLDOFF_CYCLES > 0) begin
          state_d    = HOLDOFF;
          hold_cnt_d = '0;
        end else if (state_q == HOLDOFF && hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end else if (pend_valid_d) begin
          launch       = 1'b1;
          launch_set   = pend_set_d;
          pend_valid_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d    = FIRE;
      s_d        = launch_set;
      r_d        = ~launch_set;
      q_shadow_d = launch_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_sync_q   <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      deb_cnt_q    <= '{default: '0};
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_set_q   <= 1'b0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      conflict_q   <= 1'b0;
      q_shadow_q   <= 1'b0;
    end else begin
      raw_sync_q   <= raw_sync_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_set_q   <= pend_set_d;
      s_q          <= s_d;
      r_q          <= r_d;
      conflict_q   <= conflict_d;
      q_shadow_q   <= q_shadow_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign busy     = (state_q != IDLE);
  assign conflict = conflict_q;
  assign q_shadow = q_shadow_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer: latency, glitch rejection, conflict, pending, reset abort.
module tb_sr_cmd_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic s_raw, r_raw;
  logic S, R, busy, conflict, q_shadow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sr_cmd_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (2),
    .CNT_W          (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_raw   (s_raw),
    .r_raw   (r_raw),
    .S       (S),
    .R       (R),
    .busy    (busy),
    .conflict(conflict),
    .q_shadow(q_shadow)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

`ifdef SR_CMD_REDUNDANT_FILTER_EN
  localparam logic REDUNDANT_ISSUED = 1'b0;
`else
  localparam logic REDUNDANT_ISSUED = 1'b1;
`endif

  initial begin
    reset = 1'b1;
    s_raw = 1'b0;
    r_raw = 1'b0;
    tick(3);
    chk("rst_S", S, 1'b0);
    chk("rst_R", R, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_conflict", conflict, 1'b0);
    chk("rst_q", q_shadow, 1'b0);
    reset = 1'b0;
    tick(2);

    // Set latency: first high sample at edge n, S in the cycle after n+5.
    s_raw = 1'b1;
    tick(5);
    chk("lat_S_early", S, 1'b0);
    chk("lat_busy_early", busy, 1'b0);
    tick(1);
    chk("lat_S", S, 1'b1);
    chk("lat_R", R, 1'b0);
    chk("lat_q", q_shadow, 1'b1);
    chk("lat_busy_fire", busy, 1'b1);
    tick(1);
    chk("lat_S_one", S, 1'b0);
    chk("lat_busy_h1", busy, 1'b1);
    tick(1);
    chk("lat_busy_h2", busy, 1'b1);
    tick(1);
    chk("lat_busy_done", busy, 1'b0);
    chk("lat_q_hold", q_shadow, 1'b1);
    s_raw = 1'b0;
    tick(8);

    // Clear alone.
    r_raw = 1'b1;
    tick(5);
    chk("clr_R_early", R, 1'b0);
    tick(1);
    chk("clr_R", R, 1'b1);
    chk("clr_S", S, 1'b0);
    chk("clr_q", q_shadow, 1'b0);
    r_raw = 1'b0;
    tick(10);
    chk("clr_idle", busy, 1'b0);

    // Clear request arrives in HOLDOFF and fires right after it.
    s_raw = 1'b1;
    tick(2);
    r_raw = 1'b1;
    tick(4);
    chk("pend_S", S, 1'b1);
    chk("pend_q_set", q_shadow, 1'b1);
    tick(1);
    chk("pend_S_off", S, 1'b0);
    chk("pend_R_h1", R, 1'b0);
    tick(1);
    chk("pend_R_h2", R, 1'b0);
    chk("pend_busy_h2", busy, 1'b1);
    tick(1);
    chk("pend_R", R, 1'b1);
    chk("pend_S_x", S, 1'b0);
    chk("pend_q_clr", q_shadow, 1'b0);
    tick(3);
    chk("pend_idle", busy, 1'b0);
    s_raw = 1'b0;
    r_raw = 1'b0;
    tick(10);

    // Three-cycle glitch is rejected.
    s_raw = 1'b1;
    tick(3);
    s_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("glitch_S", S, 1'b0);
      chk("glitch_busy", busy, 1'b0);
    end

    // Simultaneous rise: single conflict pulse, nothing issued.
    s_raw = 1'b1;
    r_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("cf_conflict", conflict, (i == 5));
      chk("cf_S", S, 1'b0);
      chk("cf_R", R, 1'b0);
      chk("cf_q", q_shadow, 1'b0);
    end
    s_raw = 1'b0;
    r_raw = 1'b0;
    tick(10);

    // Redundant set while q_shadow is already 1.
    s_raw = 1'b1;
    tick(6);
    chk("red_first_S", S, 1'b1);
    s_raw = 1'b0;
    tick(10);
    s_raw = 1'b1;
    tick(6);
    chk("red_S", S, REDUNDANT_ISSUED);
    chk("red_busy", busy, REDUNDANT_ISSUED);
    chk("red_q", q_shadow, 1'b1);
    s_raw = 1'b0;
    tick(10);

    // Return q_shadow to 0, then reset in the FIRE cycle of a set.
    r_raw = 1'b1;
    tick(6);
    chk("pre_rst_R", R, 1'b1);
    chk("pre_rst_q", q_shadow, 1'b0);
    r_raw = 1'b0;
    tick(10);
    s_raw = 1'b1;
    tick(6);
    chk("abort_S_fire", S, 1'b1);
    reset = 1'b1;
    tick(1);
    chk("abort_S", S, 1'b0);
    chk("abort_R", R, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_conflict", conflict, 1'b0);
    chk("abort_q", q_shadow, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk("rerun_S", S, (i == 6));
    end
    chk("rerun_q", q_shadow, 1'b1);
    s_raw = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
